// File: rtl/data_memory_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_pkg
// Description : Shared RV32I definitions for the data memory: LOAD/STORE
//               opcodes, fun3 width/sign encodings and a helper that maps
//               a store fun3 to its byte-lane mask.
// Revision    : 1.0 - initial release
// ============================================================================
package data_memory_pkg;

  // Major opcodes
  localparam logic [6:0] c_OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] c_OPC_STORE = 7'b0100011;

  // Store widths
  localparam logic [2:0] c_F3_SB  = 3'b000;
  localparam logic [2:0] c_F3_SH  = 3'b001;
  localparam logic [2:0] c_F3_SW  = 3'b010;

  // Load widths / sign handling
  localparam logic [2:0] c_F3_LB  = 3'b000;
  localparam logic [2:0] c_F3_LH  = 3'b001;
  localparam logic [2:0] c_F3_LW  = 3'b010;
  localparam logic [2:0] c_F3_LBU = 3'b100;
  localparam logic [2:0] c_F3_LHU = 3'b101;

  // Byte lanes (relative to the access address) written by a store.
  // Reserved encodings yield an empty mask so the store is dropped.
  function automatic logic [3:0] store_mask(input logic [2:0] fun3);
    logic [3:0] mask;
    mask = 4'b0000;
    case (fun3)
      c_F3_SB: mask = 4'b0001;
      c_F3_SH: mask = 4'b0011;
      c_F3_SW: mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage : data_memory_pkg
`default_nettype wire

// File: rtl/data_memory_load_extend.sv
`default_nettype none
// ============================================================================
// Module      : load_extend
// Description : Selects the sized portion of a raw little-endian word and
//               applies sign or zero extension according to RV32I fun3.
// Ports       : raw      - 32-bit word gathered from bytes A..A+3
//               fun3     - load width/sign select
//               data_out - extended load result (0 for reserved fun3)
// Revision    : 1.0 - initial release
// ============================================================================
module load_extend
  import data_memory_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [2:0]  fun3,
  output logic [31:0] data_out
);

  always_comb begin
    data_out = 32'h0000_0000;
    case (fun3)
      c_F3_LB:  data_out = {{24{raw[7]}}, raw[7:0]};
      c_F3_LH:  data_out = {{16{raw[15]}}, raw[15:0]};
      c_F3_LW:  data_out = raw;
      c_F3_LBU: data_out = {24'h000000, raw[7:0]};
      c_F3_LHU: data_out = {16'h0000, raw[15:0]};
      default:  data_out = 32'h0000_0000;
    endcase
  end

endmodule : load_extend
`default_nettype wire

// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
// Module      : data_memory
// Description : Byte-addressable little-endian RV32I data memory with
//               SB/SH/SW stores on the rising clock edge and combinational
//               LB/LH/LW/LBU/LHU loads. Unaligned accesses are allowed and
//               wrap modulo the memory size.
// Ports       : clk       - clock, stores occur on rising edge
//               reset_n   - asynchronous active-low reset, clears memory
//               mem_write - store enable (needs STORE opcode)
//               mem_read  - load enable (needs LOAD opcode)
//               addr      - byte address, upper bits beyond size ignored
//               fun3      - access width/sign select
//               opcode    - RV32I major opcode
//               data_in   - store data
//               data_out  - load result, 0 when no valid load
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory
  import data_memory_pkg::*;
#(
  parameter int size = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [31:0] addr,
  input  logic [2:0]  fun3,
  input  logic [6:0]  opcode,
  input  logic [31:0] data_in,
  output logic [31:0] data_out
);

  localparam int ADDR_W = $clog2(size);

  logic [7:0]        r_mem [size];
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] w_idx [4];
  logic [3:0]        w_be;
  logic [31:0]       w_raw;
  logic [31:0]       w_ext;
  logic              w_store_en;
  logic              w_load_en;
  logic              w_unused_addr;

  // Effective address is addr mod size; the discarded bits are folded into
  // a dummy net so they read as intentionally unused.
  assign w_base        = addr[ADDR_W-1:0];
  assign w_unused_addr = ^addr[31:ADDR_W];

  // Byte lane k addresses A+k; the natural ADDR_W-bit overflow gives the
  // modulo-size wrap for unaligned accesses near the top of memory.
  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign w_idx[k]       = w_base + ADDR_W'(k);
    assign w_raw[8*k +: 8] = r_mem[w_idx[k]];
  end

  assign w_store_en = mem_write && (opcode == c_OPC_STORE);
  assign w_be       = w_store_en ? store_mask(fun3) : 4'b0000;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < size; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_be[k]) begin
          r_mem[w_idx[k]] <= data_in[8*k +: 8];
        end
      end
    end
  end

  load_extend u_load_extend (
    .raw      (w_raw),
    .fun3     (fun3),
    .data_out (w_ext)
  );

  // Reserved load encodings already return 0 from load_extend; the reset
  // term keeps the output quiet while reset is held.
  assign w_load_en = reset_n && mem_read && (opcode == c_OPC_LOAD);
  assign data_out  = w_load_en ? w_ext : 32'h0000_0000;

endmodule : data_memory
`default_nettype wire

// File: tb/tb_data_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory
// Description : Directed self-checking bench for data_memory (size 1024).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory;

  localparam int SIZE = 1024;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_ALU   = 7'b0110011;

  logic        clk;
  logic        reset_n;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] addr;
  logic [2:0]  fun3;
  logic [6:0]  opcode;
  logic [31:0] data_in;
  logic [31:0] data_out;

  int checks = 0;
  int errors = 0;

  data_memory #(.size(SIZE)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .addr      (addr),
    .fun3      (fun3),
    .opcode    (opcode),
    .data_in   (data_in),
    .data_out  (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Apply a store across one rising edge, then drop the enable.
  task automatic store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d,
                       input logic [6:0] opc);
    @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b1;
    opcode    = opc;
    addr      = a;
    fun3      = f3;
    data_in   = d;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
  endtask

  task automatic load_check(input string tag, input logic [31:0] a, input logic [2:0] f3,
                            input logic [31:0] exp);
    mem_write = 1'b0;
    mem_read  = 1'b1;
    opcode    = OPC_LOAD;
    addr      = a;
    fun3      = f3;
    #1;
    check_eq(tag, data_out, exp);
  endtask

  initial begin
    reset_n = 1'b0; mem_write = 1'b0; mem_read = 1'b0;
    addr = '0; fun3 = '0; opcode = '0; data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    mem_read = 1'b1; opcode = OPC_LOAD; fun3 = 3'b010;
    #1;
    check_eq("reset_out", data_out, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    load_check("post_reset_lw0", 32'h0, 3'b010, 32'h0);

    // Basic width/sign sequence
    store(32'h0, 3'b010, 32'hAABBCCDD, OPC_STORE);
    store(32'h4, 3'b010, 32'h11223344, OPC_STORE);
    store(32'h0, 3'b001, 32'hFFFF1234, OPC_STORE);
    store(32'h2, 3'b001, 32'hFFFF5678, OPC_STORE);
    store(32'h0, 3'b000, 32'hFFFFFFAA, OPC_STORE);
    store(32'h1, 3'b000, 32'h000000BB, OPC_STORE);
    load_check("lw0",   32'h0, 3'b010, 32'h5678BBAA);
    load_check("lw4",   32'h4, 3'b010, 32'h11223344);
    load_check("lh0",   32'h0, 3'b001, 32'hFFFFBBAA);
    load_check("lhu2",  32'h2, 3'b101, 32'h00005678);
    load_check("lb0",   32'h0, 3'b000, 32'hFFFFFFAA);
    load_check("lbu1",  32'h1, 3'b100, 32'h000000BB);
    load_check("lh2",   32'h2, 3'b001, 32'h00005678);
    load_check("lb5",   32'h5, 3'b000, 32'h00000033);
    load_check("lhu0",  32'h0, 3'b101, 32'h0000BBAA);

    // Unaligned
    store(32'd10, 3'b010, 32'hAABBCCDD, OPC_STORE);
    load_check("lw10",  32'd10, 3'b010, 32'hAABBCCDD);
    load_check("lw8",   32'd8,  3'b010, 32'hCCDD0000);
    load_check("lbu13", 32'd13, 3'b100, 32'h000000AA);
    load_check("lh11",  32'd11, 3'b001, 32'hFFFFBBCC);

    // Gating
    store(32'h0, 3'b010, 32'hDEADBEEF, OPC_ALU);
    load_check("alu_nowrite", 32'h0, 3'b010, 32'h5678BBAA);
    store(32'h0, 3'b011, 32'hDEADBEEF, OPC_STORE);
    load_check("f3_011_nowrite", 32'h0, 3'b010, 32'h5678BBAA);
    store(32'h0, 3'b110, 32'hDEADBEEF, OPC_STORE);
    load_check("f3_110_nowrite", 32'h0, 3'b010, 32'h5678BBAA);
    load_check("ld_f3_011", 32'h0, 3'b011, 32'h0);
    load_check("ld_f3_110", 32'h0, 3'b110, 32'h0);
    load_check("ld_f3_111", 32'h0, 3'b111, 32'h0);
    mem_read = 1'b0; #1;
    check_eq("rd_off", data_out, 32'h0);
    mem_read = 1'b1; opcode = OPC_STORE; #1;
    check_eq("rd_opc_store", data_out, 32'h0);

    // Wrap at the top of memory, plus ignored upper address bits
    store(SIZE - 2, 3'b010, 32'h11223344, OPC_STORE);
    load_check("lhu_top",  SIZE - 2, 3'b101, 32'h00003344);
    load_check("lhu_wrap0", 32'h0, 3'b101, 32'h00001122);
    load_check("lw_wrap",  SIZE - 2, 3'b010, 32'h11223344);
    load_check("alias_hi", 32'h8000_0000 + SIZE - 2, 3'b101, 32'h00003344);

    // Read during write at 0x20: old data before the edge, new after it
    store(32'h20, 3'b010, 32'h01020304, OPC_STORE);
    @(negedge clk);
    load_check("rdw_before", 32'h20, 3'b010, 32'h01020304);
    mem_write = 1'b1; data_in = 32'hCAFEF00D;
    #1;
    check_eq("rdw_ld_opc_nowrite", data_out, 32'h01020304);
    opcode = OPC_STORE;
    @(posedge clk);
    #1;
    mem_write = 1'b0; opcode = OPC_LOAD;
    #1;
    check_eq("rdw_after", data_out, 32'hCAFEF00D);

    // Mid-cycle reset pulse aborting a pending store
    @(negedge clk);
    mem_write = 1'b1; mem_read = 1'b1; opcode = OPC_STORE;
    addr = 32'h40; fun3 = 3'b010; data_in = 32'h55667788;
    #2;
    reset_n = 1'b0;
    opcode = OPC_LOAD; addr = 32'h4;
    #1;
    check_eq("rst_out_lw4", data_out, 32'h0);
    opcode = OPC_STORE; addr = 32'h40;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset_n = 1'b1;
    mem_write = 1'b0;
    load_check("rst_lw0",  32'h0,  3'b010, 32'h0);
    load_check("rst_lw4",  32'h4,  3'b010, 32'h0);
    load_check("rst_lw20", 32'h20, 3'b010, 32'h0);
    load_check("rst_aborted_store", 32'h40, 3'b010, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_data_memory
`default_nettype wire
